ahb_mux_s2m_n: RTL and testbench
================================

Name: ahb_mux_s2m_n

Overview:
- Parametrised AHB slave-to-master response multiplexer for N slaves plus a built-in default slave.
- Registers the address-phase slave select, then routes HREADY, HRESP and HRDATA from the selected slave to the master during the data phase.
- Adds two functions: an AHB-compliant two-cycle ERROR response for unmapped accesses, and a per-transfer stall watchdog.
- Sits between the address decoder and the master, in the bus fabric.

Parameters:
- NUM_SLAVES, 2, number of real slaves (1..16).
- DATA_W, 32, HRDATA width.
- TIMEOUT_CYCLES, 0, consecutive wait states before the watchdog aborts a transfer; 0 disables the watchdog.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous, active-high reset, sampled on the HCLK rising edge.
- HSEL  in  NUM_SLAVES  address-phase slave selects from the decoder; bit i selects slave i.
- HSEL_Default  in  1  address phase hits no slave.
- HTRANS  in  2  address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HREADY_S  in  NUM_SLAVES  per-slave HREADYOUT.
- HRESP_S  in  2*NUM_SLAVES  per-slave HRESP; slave i occupies bits [2i+1:2i].
- HRDATA_S  in  DATA_W*NUM_SLAVES  per-slave read data; slave i occupies bits [DATA_W*(i+1)-1:DATA_W*i].
- HREADY  out  1  muxed ready to the master; also fed back internally to gate the address-phase capture.
- HRESP  out  2  muxed response (OKAY=0, ERROR=1).
- HRDATA  out  DATA_W  muxed read data.
- TIMEOUT  out  1  one-cycle pulse when the watchdog aborts a transfer.

Behaviour:
- Reset (HRESET high at a clock edge):
  - sel_q=0, def_q=0, state=FWD, wait counter=0, TIMEOUT=0.
  - Outputs: HREADY=1, HRESP=OKAY, HRDATA=0.
  - Reset mid-transfer abandons the transfer immediately; there is no completion.
- Capture: on each edge where HREADY=1 and state=FWD:
  - sel_q <= one-hot HSEL. If HSEL has several bits set, the lowest index wins.
  - def_q <= HSEL_Default & HTRANS[1] (NONSEQ/SEQ only).
  - When HREADY=0, the captured values hold.
- State FWD, combinational outputs:
  - sel_q has bit i set: HREADY=HREADY_S[i], HRESP=HRESP_S slice i, HRDATA=HRDATA_S slice i.
  - sel_q=0 and def_q=0: HREADY=1, HRESP=OKAY, HRDATA=0. IDLE/BUSY to the default slave gets zero-wait OKAY.
  - def_q=1: outputs HREADY=0, HRESP=ERROR; next state ERR2.
- State ERR2:
  - Outputs HREADY=1, HRESP=ERROR, HRDATA=0.
  - Next edge: capture a new address phase exactly as in FWD; state -> FWD.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle sel_q!=0, state=FWD and the selected HREADY_S=0.
  - It clears when HREADY=1.
  - When the count reaches TIMEOUT_CYCLES-1 with the slave still stalled, the next cycle enters ERR1:
    - TIMEOUT pulses high for 1 cycle.
    - sel_q is cleared.
  - State ERR1 outputs HREADY=0, HRESP=ERROR; next state ERR2.
  - The aborted slave's later responses are ignored.
- Slave-issued ERROR: forwarded transparently in FWD; the slave owns the two-cycle sequence.
- Counter width: clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.
- Latency: zero-cycle combinational forwarding in FWD. The default-slave error takes exactly 2 data-phase cycles.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - RSP_OKAY/ERROR/RETRY/SPLIT.
  - mux state enum {FWD, ERR1, ERR2}.
- Sub-module ahb_err_resp: the ERR1/ERR2 two-cycle error generator, driven by a start pulse, with outputs err_active, err_ready and err_last. It is reused by the future default slave.

Test Plan:
- Reset: hold HRESET=1 for 2 cycles, then release -> HREADY=1, HRESP=0, HRDATA=0, TIMEOUT=0.
- Forwarding:
  - NONSEQ with HSEL=2'b10, HREADY=1.
  - Next cycle HRDATA_S slice1=32'hDEADBEEF, HREADY_S[1]=0 for 2 cycles, then 1.
  - Expect HREADY=0,0,1 and HRDATA=32'hDEADBEEF when HREADY=1.
- Default slave:
  - NONSEQ with HSEL_Default=1 -> data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then the next transfer proceeds.
  - IDLE with HSEL_Default=1 -> HREADY=1, HRESP=0 with no wait.
- Watchdog: TIMEOUT_CYCLES=4, slave0 holds HREADY_S[0]=0 indefinitely -> after 4 stall cycles TIMEOUT=1 for one cycle, then ERROR with HREADY=0 followed by ERROR with HREADY=1; a subsequent slave1 access completes normally.
- Multi-hot and back-to-back:
  - HSEL=2'b11 -> slave0 data is routed.
  - Alternate slave0/slave1 NONSEQ every cycle with HREADY_S=1 -> each data phase shows the correct slice with zero waits.
- Reset mid-stall: assert HRESET during a slave1 wait state -> next cycle HREADY=1, HRESP=0, TIMEOUT=0, sel_q=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and response-mux state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] RSP_OKAY  = 2'd0;
    localparam logic [1:0] RSP_ERROR = 2'd1;
    localparam logic [1:0] RSP_RETRY = 2'd2;
    localparam logic [1:0] RSP_SPLIT = 2'd3;

    typedef enum logic [1:0] {
        FWD,
        ERR1,
        ERR2
    } mux_state_e;

endpackage

// File: rtl/ahb_err_resp.sv
// Two-cycle AHB ERROR sequencer: ERR1 (wait) then ERR2 (ready).
// skip enters ERR2 directly when the first cycle was produced elsewhere.
module ahb_err_resp
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       skip,
    output mux_state_e state,
    output logic       err_active,
    output logic       err_ready,
    output logic       err_last
);

    mux_state_e state_q;
    mux_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FWD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FWD: begin
                if (start)     state_d = ERR1;
                else if (skip) state_d = ERR2;
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = FWD;
            default: state_d = FWD;
        endcase
    end

    assign state      = state_q;
    assign err_active = (state_q != FWD);
    assign err_ready  = (state_q == ERR2);
    assign err_last   = (state_q == ERR2);

endmodule

// File: rtl/ahb_mux_s2m_n.sv
// AHB slave-to-master response mux with default-slave ERROR
// and a per-transfer stall watchdog.
module ahb_mux_s2m_n
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES     = 2,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_SLAVES-1:0]      HSEL,
    input  logic                       HSEL_Default,
    input  logic [1:0]                 HTRANS,
    input  logic [NUM_SLAVES-1:0]      HREADY_S,
    input  logic [2*NUM_SLAVES-1:0]    HRESP_S,
    input  logic [DATA_W*NUM_SLAVES-1:0] HRDATA_S,
    output logic                       HREADY,
    output logic [1:0]                 HRESP,
    output logic [DATA_W-1:0]          HRDATA,
    output logic                       TIMEOUT
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIM   = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LIM = CW'(LIM);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NUM_SLAVES-1:0] sel_q;
    logic [NUM_SLAVES-1:0] hsel_oh;
    logic                  def_q;
    logic [CW-1:0]         cnt_q;
    logic                  timeout_q;

    logic              mux_rdy;
    logic [1:0]        mux_rsp;
    logic [DATA_W-1:0] mux_data;

    mux_state_e state;
    logic err_active;
    logic err_ready;
    logic err_last;
    logic stall;
    logic fire;
    logic def_err;
    logic unused;

    // Lowest set bit wins on multi-hot selects.
    assign hsel_oh = HSEL & (~HSEL + NUM_SLAVES'(1));

    always_comb begin
        mux_rdy  = 1'b0;
        mux_rsp  = '0;
        mux_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                mux_rdy  = mux_rdy | HREADY_S[i];
                mux_rsp  = mux_rsp | HRESP_S[2*i +: 2];
                mux_data = mux_data | HRDATA_S[DATA_W*i +: DATA_W];
            end
        end
    end

    assign stall   = ~err_active & (|sel_q) & ~mux_rdy;
    assign fire    = WD_EN & stall & (cnt_q == CNT_LIM);
    assign def_err = ~err_active & ~(|sel_q) & def_q;

    ahb_err_resp u_err (
        .clk        (HCLK),
        .rst        (HRESET),
        .start      (fire),
        .skip       (def_err),
        .state      (state),
        .err_active (err_active),
        .err_ready  (err_ready),
        .err_last   (err_last)
    );

    always_comb begin
        HREADY = 1'b1;
        HRESP  = RSP_OKAY;
        HRDATA = '0;
        if (err_active) begin
            HREADY = err_ready;
            HRESP  = RSP_ERROR;
        end else if (|sel_q) begin
            HREADY = mux_rdy;
            HRESP  = mux_rsp;
            HRDATA = mux_data;
        end else if (def_q) begin
            HREADY = 1'b0;
            HRESP  = RSP_ERROR;
        end
    end

    // HREADY is only high in FWD or ERR2, so it alone gates capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else if (fire) begin
            sel_q <= '0;
        end else if (HREADY) begin
            sel_q <= hsel_oh;
            def_q <= HSEL_Default & HTRANS[1];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= fire;
            if (HREADY || fire)
                cnt_q <= '0;
            else if (WD_EN && stall && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign TIMEOUT = timeout_q;
    assign unused  = ^{HTRANS[0], err_last, state};

endmodule

// File: tb/tb_ahb_mux_s2m_n.sv
// Scoreboard bench for ahb_mux_s2m_n with two slaves and a 4-cycle watchdog.
module tb_ahb_mux_s2m_n;

    typedef struct packed {
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] data;
        logic        chkd;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  hsel = '0;
    logic        hdef = 1'b0;
    logic [1:0]  htrans = '0;
    logic [1:0]  hready_s = 2'b11;
    logic [3:0]  hresp_s = '0;
    logic [63:0] hrdata_s = '0;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        timeout;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    ahb_mux_s2m_n #(
        .NUM_SLAVES     (2),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK         (clk),
        .HRESET       (rst),
        .HSEL         (hsel),
        .HSEL_Default (hdef),
        .HTRANS       (htrans),
        .HREADY_S     (hready_s),
        .HRESP_S      (hresp_s),
        .HRDATA_S     (hrdata_s),
        .HREADY       (hready),
        .HRESP        (hresp),
        .HRDATA       (hrdata),
        .TIMEOUT      (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic r,
                              input logic [1:0] s, input logic [31:0] d,
                              input logic cd, input logic t);
        exp_t e;
        e.rdy  = r;
        e.rsp  = s;
        e.data = d;
        e.chkd = cd;
        e.to   = t;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            logic  ok;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            ok = (hready === e.rdy) && (hresp === e.rsp) &&
                 (timeout === e.to) && (!e.chkd || hrdata === e.data);
            if (ok) passed++;
            else $display("FAIL %s: got rdy=%b rsp=%0d data=%h to=%b want rdy=%b rsp=%0d data=%h(chk=%b) to=%b",
                          n, hready, hresp, hrdata, timeout,
                          e.rdy, e.rsp, e.data, e.chkd, e.to);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("reset", 1, 0, 32'h0, 1, 0);
        tick();

        // forwarding with two wait states
        hsel = 2'b10; htrans = 2'd2; hready_s = 2'b11;
        expect_out("fwd_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0; hready_s = 2'b01;
        hrdata_s[63:32] = 32'hDEADBEEF;
        expect_out("fwd_wait1", 0, 0, 32'h0, 0, 0);
        tick();
        expect_out("fwd_wait2", 0, 0, 32'h0, 0, 0);
        tick();
        hready_s = 2'b11;
        expect_out("fwd_data", 1, 0, 32'hDEADBEEF, 1, 0);
        tick();

        // default slave NONSEQ -> two-cycle ERROR, then next transfer
        hdef = 1'b1; htrans = 2'd2; hsel = 2'b00;
        expect_out("def_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hdef = 1'b0; hsel = 2'b01; htrans = 2'd2;
        expect_out("def_err1", 0, 1, 32'h0, 1, 0);
        tick();
        expect_out("def_err2", 1, 1, 32'h0, 1, 0);
        tick();
        hrdata_s[31:0] = 32'h11112222;
        hdef = 1'b1; htrans = 2'd0; hsel = 2'b00;
        expect_out("def_next", 1, 0, 32'h11112222, 1, 0);
        tick();
        hdef = 1'b0;
        expect_out("def_idle", 1, 0, 32'h0, 1, 0);
        tick();

        // multi-hot and back-to-back alternation
        hsel = 2'b11; htrans = 2'd2;
        expect_out("mh_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hrdata_s = {32'hBBBB1111, 32'hAAAA0000};
        hsel = 2'b10;
        expect_out("mh_s0", 1, 0, 32'hAAAA0000, 1, 0);
        tick();
        hsel = 2'b01;
        expect_out("b2b_s1a", 1, 0, 32'hBBBB1111, 1, 0);
        tick();
        hsel = 2'b10;
        expect_out("b2b_s0", 1, 0, 32'hAAAA0000, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0;
        expect_out("b2b_s1b", 1, 0, 32'hBBBB1111, 1, 0);
        tick();
        expect_out("b2b_idle", 1, 0, 32'h0, 1, 0);
        tick();

        // slave-issued ERROR forwarded unchanged
        hsel = 2'b01; htrans = 2'd2;
        expect_out("serr_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0; hready_s = 2'b10; hresp_s = 4'b0001;
        expect_out("serr_1", 0, 1, 32'h0, 0, 0);
        tick();
        hready_s = 2'b11;
        expect_out("serr_2", 1, 1, 32'hAAAA0000, 1, 0);
        tick();
        hresp_s = 4'b0000;
        expect_out("serr_done", 1, 0, 32'h0, 1, 0);
        tick();

        // watchdog on slave0
        hsel = 2'b01; htrans = 2'd2;
        expect_out("wd_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0; hready_s = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            expect_out($sformatf("wd_stall%0d", k), 0, 0, 32'h0, 0, 0);
            tick();
        end
        expect_out("wd_timeout", 0, 1, 32'h0, 1, 1);
        tick();
        hsel = 2'b10; htrans = 2'd2;
        expect_out("wd_err2", 1, 1, 32'h0, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0;
        expect_out("wd_s1", 1, 0, 32'hBBBB1111, 1, 0);
        tick();
        expect_out("wd_after", 1, 0, 32'h0, 1, 0);
        tick();

        // reset during a slave1 wait state
        hready_s = 2'b11; hsel = 2'b10; htrans = 2'd2;
        expect_out("rst_addr", 1, 0, 32'h0, 1, 0);
        tick();
        hsel = 2'b00; htrans = 2'd0; hready_s = 2'b01; rst = 1'b1;
        expect_out("rst_stall", 0, 0, 32'h0, 0, 0);
        tick();
        rst = 1'b0;
        expect_out("rst_after", 1, 0, 32'h0, 1, 0);
        tick();

        tick();
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
